// File: rtl/spi_frame_pkg.sv
// Shared SPI framing types: command codes, host FSM states, and the segment record size.
package spi_frame_pkg;

  typedef enum logic [7:0] {
    CMD_NO_OP      = 8'd0,
    CMD_STATUS     = 8'd1,
    CMD_WRITE_FIFO = 8'd2
  } command_e;

  localparam int SegmentBytes = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP
  } host_state_e;

endpackage

// File: rtl/spi_sck_divider.sv
// SPI clock generator: sck idles low while disabled and toggles every ClkDiv clk cycles when enabled.
// rise_o/fall_o are high on the clk cycle whose closing edge changes sck.
module spi_sck_divider #(
  parameter int ClkDiv = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic sck_o
);

  localparam logic [7:0] DivMax = 8'(ClkDiv - 1);

  logic [7:0] div_q, div_d;
  logic       sck_q, sck_d;
  logic       tick;

  assign tick = en_i && (div_q == DivMax);

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    div_d = div_q;
    sck_d = sck_q;
    if (!en_i) begin
      div_d = 8'd0;
      sck_d = 1'b0;
    end else if (tick) begin
      div_d = 8'd0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 8'd0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign rise_o = tick && !sck_q;
  assign fall_o = tick && sck_q;
  assign sck_o  = sck_q;

endmodule

// File: rtl/spi_host_frame_tx.sv
// SPI mode-0 host that frames one command byte plus 0..MaxPayload payload bytes per accepted request.
// Optional build macro SPI_HOST_FRAME_TX_RESP_ALL_EN exposes every received MISO byte.
module spi_host_frame_tx
  import spi_frame_pkg::*;
#(
  parameter int ClkDiv     = 4,
  parameter int MaxPayload = SegmentBytes,
  parameter int CsSetup    = 2,
  parameter int CsGap      = 4,
  localparam int LenW      = $clog2(MaxPayload) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd,
  input  logic [8*MaxPayload-1:0] payload,
  input  logic [LenW-1:0]         payload_len,
  output logic                    resp_valid,
  output logic [7:0]              resp_status,
  output logic                    busy,
  output logic                    spi_sck,
  output logic                    spi_mosi,
  output logic                    spi_cs,
  input  logic                    spi_miso
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
  ,
  output logic                    resp_byte_valid,
  output logic [7:0]              resp_byte
`endif
);

  localparam logic [7:0]      SetupMax = 8'(CsSetup - 1);
  localparam logic [7:0]      GapMax   = 8'(CsGap - 1);
  localparam logic [LenW-1:0] LenMax   = LenW'(MaxPayload);

  host_state_e             state_q, state_d;
  logic [7:0]              tmr_q, tmr_d;
  logic [2:0]              bit_q, bit_d;
  logic [LenW-1:0]         idx_q, idx_d;
  logic [LenW-1:0]         len_q, len_d;
  logic [7:0]              sh_q, sh_d;
  logic [8*MaxPayload-1:0] payload_q, payload_d;
  logic [7:0]              rx_q, rx_d;
  logic [7:0]              stat_cap_q, stat_cap_d;
  logic [7:0]              resp_status_q, resp_status_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    cs_q, cs_d;
  logic [1:0]              sync_q;
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
  logic [7:0]              byte_q, byte_d;
  logic                    byte_valid_q, byte_valid_d;
`endif

  logic sck_rise, sck_fall;

  spi_sck_divider #(.ClkDiv(ClkDiv)) u_div (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == ST_SHIFT),
    .rise_o(sck_rise),
    .fall_o(sck_fall),
    .sck_o (spi_sck)
  );

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    bit_d         = bit_q;
    idx_d         = idx_q;
    len_d         = len_q;
    sh_d          = sh_q;
    payload_d     = payload_q;
    rx_d          = rx_q;
    stat_cap_d    = stat_cap_q;
    resp_status_d = resp_status_q;
    resp_valid_d  = 1'b0;
    cs_d          = cs_q;
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
    byte_d        = byte_q;
    byte_valid_d  = 1'b0;
`endif

    if (sck_rise) rx_d = {rx_q[6:0], sync_q[1]};

    case (state_q)
      ST_IDLE: begin
        tmr_d = 8'd0;
        if (cmd_valid) begin
          state_d   = ST_CS_SETUP;
          cs_d      = 1'b0;
          sh_d      = cmd;
          payload_d = payload;
          len_d     = (payload_len > LenMax) ? LenMax : payload_len;
          idx_d     = '0;
          bit_d     = 3'd0;
        end
      end
      ST_CS_SETUP: begin
        if (tmr_q == SetupMax) begin
          tmr_d   = 8'd0;
          state_d = ST_SHIFT;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (sck_fall) begin
          if (bit_q == 3'd7) begin
            // Byte boundary: rx_q holds all 8 bits since the last rise was half a period ago.
            bit_d = 3'd0;
            if (idx_q == '0) stat_cap_d = rx_q;
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
            byte_d       = rx_q;
            byte_valid_d = 1'b1;
`endif
            if (idx_q < len_q) begin
              idx_d     = idx_q + LenW'(1);
              sh_d      = payload_q[7:0];
              payload_d = payload_q >> 8;
            end else begin
              sh_d    = 8'd0;
              state_d = ST_CS_HOLD;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
          end
        end
      end
      ST_CS_HOLD: begin
        if (tmr_q == SetupMax) begin
          tmr_d         = 8'd0;
          cs_d          = 1'b1;
          state_d       = ST_GAP;
          resp_valid_d  = 1'b1;
          resp_status_d = stat_cap_q;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (tmr_q == GapMax) begin
          tmr_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tmr_q         <= 8'd0;
      bit_q         <= 3'd0;
      idx_q         <= '0;
      len_q         <= '0;
      sh_q          <= 8'd0;
      payload_q     <= '0;
      rx_q          <= 8'd0;
      stat_cap_q    <= 8'd0;
      resp_status_q <= 8'd0;
      resp_valid_q  <= 1'b0;
      cs_q          <= 1'b1;
      sync_q        <= 2'b00;
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
      byte_q        <= 8'd0;
      byte_valid_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      bit_q         <= bit_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      sh_q          <= sh_d;
      payload_q     <= payload_d;
      rx_q          <= rx_d;
      stat_cap_q    <= stat_cap_d;
      resp_status_q <= resp_status_d;
      resp_valid_q  <= resp_valid_d;
      cs_q          <= cs_d;
      sync_q        <= {sync_q[0], spi_miso};
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
      byte_q        <= byte_d;
      byte_valid_q  <= byte_valid_d;
`endif
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign spi_cs      = cs_q;
  assign spi_mosi    = sh_q[7];
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
  assign resp_byte_valid = byte_valid_q;
  assign resp_byte       = byte_q;
`endif

endmodule

// File: tb/tb_spi_host_frame_tx.sv
// Directed bench for spi_host_frame_tx with a mode-0 secondary model that answers a fixed reply byte.
// Define SPI_HOST_FRAME_TX_RESP_ALL_EN to also check the per-byte response outputs.
module tb_spi_host_frame_tx;
  import spi_frame_pkg::*;

  localparam int ClkDiv     = 4;
  localparam int MaxPayload = 4;
  localparam int CsSetup    = 2;
  localparam int CsGap      = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd = 8'd0;
  logic [31:0] payload = 32'd0;
  logic [2:0]  payload_len = 3'd0;
  logic        resp_valid;
  logic [7:0]  resp_status;
  logic        busy;
  logic        spi_sck, spi_mosi, spi_cs;
  logic        spi_miso = 1'b0;
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
  logic        resp_byte_valid;
  logic [7:0]  resp_byte;
  int          bv_cnt = 0;
  int          bv_bad = 0;
`endif

  spi_host_frame_tx #(
    .ClkDiv(ClkDiv), .MaxPayload(MaxPayload), .CsSetup(CsSetup), .CsGap(CsGap)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .payload(payload), .payload_len(payload_len),
    .resp_valid(resp_valid), .resp_status(resp_status), .busy(busy),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso)
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
    , .resp_byte_valid(resp_byte_valid), .resp_byte(resp_byte)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Secondary model: presents reply_byte MSB first for every byte of the frame.
  logic [7:0] reply_byte = 8'h00;
  logic [7:0] s_sr = 8'h00;
  always @(negedge spi_cs) begin
    s_sr     = reply_byte;
    spi_miso = s_sr[7];
  end
  always @(negedge spi_sck) begin
    if (spi_cs === 1'b0) begin
      s_sr     = {s_sr[6:0], s_sr[7]};
      spi_miso = s_sr[7];
    end
  end

  // Wire monitor: counts sck rises and logs MOSI bytes.
  int         rises = 0;
  int         nbytes = 0;
  int         m_bit = 0;
  logic [7:0] m_sr = 8'h00;
  logic [7:0] byte_log [8];
  always @(negedge spi_cs) m_bit = 0;
  always @(posedge spi_sck) begin
    if (spi_cs === 1'b0) begin
      rises++;
      m_sr = {m_sr[6:0], spi_mosi};
      m_bit++;
      if (m_bit == 8) begin
        if (nbytes < 8) byte_log[nbytes] = m_sr;
        nbytes++;
        m_bit = 0;
      end
    end
  end

  int cs_low_cnt = 0;
  int resp_cnt = 0;
  int hi_run = 0;
  int last_gap = 0;
  always @(negedge clk) begin
    if (spi_cs === 1'b0) begin
      cs_low_cnt++;
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end else begin
      hi_run++;
    end
    if (resp_valid === 1'b1) resp_cnt++;
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
    if (resp_byte_valid === 1'b1) begin
      bv_cnt++;
      if (resp_byte !== 8'hA5) bv_bad++;
    end
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rises      = 0;
    nbytes     = 0;
    cs_low_cnt = 0;
    resp_cnt   = 0;
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
    bv_cnt = 0;
    bv_bad = 0;
`endif
  endtask

  // One-cycle request, then scramble the inputs to show they were latched.
  task automatic send(input logic [7:0] c, input logic [31:0] p, input logic [2:0] len);
    @(negedge clk);
    cmd         = c;
    payload     = p;
    payload_len = len;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd         = 8'hFF;
    payload     = 32'h5555_5555;
    payload_len = 3'd0;
  endtask

  task automatic wait_resp(input string tag);
    int n;
    logic seen;
    seen = 1'b0;
    for (n = 0; n < 4000 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_resp_seen"}, 32'(seen), 32'd1);
    for (n = 0; n < 100 && cmd_ready !== 1'b1; n++) @(negedge clk);
  endtask

  logic [7:0] exp_b [5];

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_status", 32'(resp_status), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // CMD_STATUS, no payload, secondary replies 0x10.
    reply_byte = 8'h10;
    clear_mon();
    send(CMD_STATUS, 32'h0, 3'd0);
    check("a_busy", 32'(busy), 32'd1);
    check("a_ready_low", 32'(cmd_ready), 32'd0);
    wait_resp("a");
    repeat (5) @(negedge clk);
    check("a_rises", 32'(rises), 32'd8);
    check("a_mosi", 32'(byte_log[0]), 32'h01);
    check("a_status", 32'(resp_status), 32'h10);
    check("a_resp_cnt", 32'(resp_cnt), 32'd1);
    check("a_cs_low", 32'(cs_low_cnt), 32'(16*ClkDiv + 2*CsSetup));

    // CMD_WRITE_FIFO with a full segment.
    reply_byte = 8'h3C;
    clear_mon();
    send(CMD_WRITE_FIFO, 32'hEFBE_ADDE, 3'd4);
    wait_resp("b");
    check("b_rises", 32'(rises), 32'd40);
    check("b_nbytes", 32'(nbytes), 32'd5);
    exp_b = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 5; i++) check($sformatf("b_mosi%0d", i), 32'(byte_log[i]), 32'(exp_b[i]));
    check("b_status", 32'(resp_status), 32'h3C);
    check("b_cs_low", 32'(cs_low_cnt), 32'(5*16*ClkDiv + 2*CsSetup));

    // Back-to-back frames with cmd_valid held high.
    reply_byte = 8'h22;
    clear_mon();
    @(negedge clk);
    cmd = CMD_WRITE_FIFO; payload = 32'h0000_0077; payload_len = 3'd1;
    cmd_valid = 1'b1;
    begin
      int n;
      logic seen;
      seen = 1'b0;
      for (n = 0; n < 2000 && !seen; n++) begin
        @(negedge clk);
        if (resp_valid === 1'b1) seen = 1'b1;
      end
      check("c_first_resp", 32'(seen), 32'd1);
      for (n = 0; n < 50 && cmd_ready !== 1'b1; n++) @(negedge clk);
      check("c_gap_cycles", 32'(n), 32'(CsGap));
    end
    @(negedge clk);
    check("c_restart_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    wait_resp("c2");
    check("c_cs_high_gap", 32'(last_gap), 32'(CsGap + 1));
    check("c_resp_cnt", 32'(resp_cnt), 32'd2);
    check("c_rises", 32'(rises), 32'd32);

    // Reset asserted at bit 3 of payload byte 2.
    reply_byte = 8'h66;
    clear_mon();
    send(CMD_WRITE_FIFO, 32'h4433_2211, 3'd4);
    for (int n = 0; n < 4000 && rises < 29; n++) @(negedge clk);
    check("d_rises_at_reset", 32'(rises), 32'd29);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("d_cs", 32'(spi_cs), 32'd1);
    check("d_sck", 32'(spi_sck), 32'd0);
    check("d_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("d_no_resp", 32'(resp_cnt), 32'd0);
    check("d_status", 32'(resp_status), 32'd0);
    reply_byte = 8'h5A;
    clear_mon();
    send(CMD_STATUS, 32'h0, 3'd0);
    wait_resp("d2");
    check("d2_rises", 32'(rises), 32'd8);
    check("d2_status", 32'(resp_status), 32'h5A);

    // Oversized payload_len clamps to MaxPayload.
    reply_byte = 8'hA5;
    clear_mon();
    send(CMD_WRITE_FIFO, 32'h4433_2211, 3'd7);
    wait_resp("e");
    check("e_rises", 32'(rises), 32'd40);
    exp_b = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 5; i++) check($sformatf("e_mosi%0d", i), 32'(byte_log[i]), 32'(exp_b[i]));
    check("e_status", 32'(resp_status), 32'hA5);
`ifdef SPI_HOST_FRAME_TX_RESP_ALL_EN
    check("e_byte_valid_cnt", 32'(bv_cnt), 32'd5);
    check("e_byte_bad", 32'(bv_bad), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_host_frame_tx.md
Name: spi_host_frame_tx

Overview:
- SPI main (initiator) that drives the same 4-wire SPI link consumed by the board's SPI secondary / motion-segment FIFO path.
- Frames one transaction per accepted command:
  - CS low;
  - command byte (CMD_NO_OP=0, CMD_STATUS=1, CMD_WRITE_FIFO=2);
  - 0..MaxPayload payload bytes;
  - CS high.
- Captures the secondary's reply byte (FIFO empty-slot count) shifted back during the command byte.
- Used as on-FPGA host emulator for loopback bring-up and as a bench driver for the receive path.

Parameters:
- ClkDiv, 4: sck half-period in clk cycles; legal range 2..255.
- MaxPayload, 4: maximum payload bytes per frame; one MotionSegment record is 4 bytes.
- CsSetup, 2: clk cycles from CS falling to first sck edge, and from last sck edge to CS rising.
- CsGap, 4: minimum clk cycles CS stays high between frames.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  request a frame
- cmd_ready  out  1  high only in IDLE; frame accepted when cmd_valid & cmd_ready
- cmd  in  8  command byte
- payload  in  8*MaxPayload  payload bytes; byte 0 = bits [7:0], sent first
- payload_len  in  $clog2(MaxPayload)+1  payload byte count; values > MaxPayload clamp to MaxPayload
- resp_valid  out  1  one-cycle pulse after frame completes
- resp_status  out  8  byte received from MISO during the command byte; held until next resp_valid
- busy  out  1  high from accept until CS returns high and CsGap elapses
- spi_sck  out  1  idle low
- spi_mosi  out  1  MSB first
- spi_cs  out  1  active low; idle high
- spi_miso  in  1  sampled on sck rising edge; 2-flop synchronised

Behaviour:
- Reset values:
  - spi_cs=1, spi_sck=0, spi_mosi=0;
  - cmd_ready=1, busy=0, resp_valid=0, resp_status=0;
  - state=IDLE.
- SPI mode 0:
  - mosi changes on sck falling edge, or during CS_SETUP for bit 7 of the first byte;
  - miso is sampled on the clk cycle that raises sck, using the synchroniser output.
  - Synchroniser latency is 2 clk, so ClkDiv ≥ 2 is required.
- cmd, payload and payload_len are latched on accept; later input changes are ignored.
- FSM:
  - IDLE: on accept -> CS_SETUP and drive cs=0.
  - CS_SETUP: after CsSetup cycles -> SHIFT, with byte index 0 = cmd.
  - SHIFT: 8 sck periods, each 2*ClkDiv clk cycles.
    - After bit 0 rises and sck falls:
      - if index < payload_len -> next byte;
      - otherwise -> CS_HOLD.
    - There is no gap between bytes; sck is continuous within a frame.
  - CS_HOLD: after CsSetup cycles, cs=1 -> GAP; resp_valid pulses on the cs-rising cycle.
  - GAP: after CsGap cycles -> IDLE.
- Frame length on the wire is exactly (1+payload_len)*8 sck rising edges.
- resp_status is updated only from the bits shifted during the command byte.
- back-to-back: cmd_valid held high starts the next frame on the first IDLE cycle; cmd_ready rises in that same cycle.
- reset mid-frame: next cycle cs=1, sck=0, state IDLE, no resp_valid. The secondary sees cs rise and returns to idle.
- Counters: use a bit counter of 3 bits and a divider counter of 8 bits, with wrap handled explicitly.

Optional Feature:
- SPI_HOST_FRAME_TX_RESP_ALL_EN
- Defined:
  - adds outputs resp_byte_valid (1) and resp_byte (8);
  - pulses once per completed byte, including the command byte, with the full MISO byte.
- Undefined:
  - ports absent; only resp_status is captured.

Decomposition:
- Shared package spi_frame_pkg holds:
  - command_e (CMD_NO_OP=0, CMD_STATUS=1, CMD_WRITE_FIFO=2), shared with the receive top;
  - localparam SegmentBytes=4.
- Sub-module spi_sck_divider: produces one-cycle rise/fall strobes and the sck level, with enable and reset.

Test Plan:
- CMD_STATUS, payload_len=0; model secondary replies 8'h10 -> 8 sck rises; mosi shows 0x01 MSB first; resp_status=8'h10; resp_valid once; cs low for exactly 16*ClkDiv+2*CsSetup cycles.
- CMD_WRITE_FIFO, payload 0xDE,0xAD,0xBE,0xEF -> 40 sck rises; mosi bytes 02,DE,AD,BE,EF; looped into spi_secondary+fifo, the fifo empty-slot count drops by 1.
- Two frames with cmd_valid held high -> cs high for exactly CsGap+... cycles between frames; second frame starts on the first IDLE cycle; two resp_valid pulses.
- Reset asserted at bit 3 of payload byte 2 -> cs=1 and sck=0 on the next cycle; no resp_valid; the next frame completes normally.
- payload_len=7 with MaxPayload=4 -> clamped; 5 bytes sent.
- With SPI_HOST_FRAME_TX_RESP_ALL_EN and a secondary echoing 0xA5 -> resp_byte_valid ×5, each resp_byte=0xA5.
